// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} hz_state_t;

    localparam int unsigned XZR_IDX_DEF = 31;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the LDUR in EX and the operands of the ID instruction.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned XZR_IDX = XZR_IDX_DEF
) (
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hazard
);

    localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

    always_comb begin
        hazard = ex_memread && (ex_rd != XZR) &&
                 ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush sequencer: load-use bubbles, branch flushes, dmem wait states.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles performance counter output.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned XZR_IDX      = XZR_IDX_DEF,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MAX_WAIT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_pcsrc,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int unsigned WC_W = $clog2(MAX_WAIT + 2);
    localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT + 1);
    localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYC - 1);

    hz_state_t       state_q, state_d, eff_state;
    logic [1:0]      lu_cnt_q, lu_cnt_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic            hazard;
    logic            freeze, bubble, flush;

    hazard_detect #(
        .REG_W   (REG_W),
        .XZR_IDX (XZR_IDX)
    ) u_detect (
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .hazard     (hazard)
    );

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;

        // Once memory is ready, the wait cycle itself is decided by the state it interrupted.
        eff_state = state_q;
        if (state_q == MEM_WAIT && !dmem_busy) begin
            eff_state = (lu_cnt_q != 2'd0) ? LU_STALL : RUN;
        end

        if (eff_state == MEM_WAIT) begin
            freeze = 1'b1;
            if (wait_cnt_q != WAIT_SAT) begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
        end else if (dmem_busy) begin
            freeze     = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WC_W'(1);
        end else if (mem_pcsrc) begin
            flush      = 1'b1;
            state_d    = RUN;
            lu_cnt_d   = 2'd0;
            wait_cnt_d = '0;
        end else if (eff_state == LU_STALL) begin
            bubble     = 1'b1;
            wait_cnt_d = '0;
            if (lu_cnt_q <= 2'd1) begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end else begin
                state_d  = LU_STALL;
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end else if (hazard) begin
            bubble     = 1'b1;
            wait_cnt_d = '0;
            if (LU_STALL_CYC <= 1) begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end else begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_INIT;
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
        end

        timeout_d = timeout_q | (wait_cnt_d == WAIT_SAT);

        pc_en        = !(freeze || bubble);
        if_id_en     = !(freeze || bubble);
        id_ex_en     = !freeze;
        ex_mem_en    = !freeze;
        mem_wb_en    = !freeze;
        if_id_flush  = flush;
        id_ex_flush  = flush || bubble;
        ex_mem_flush = flush;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            lu_cnt_q   <= 2'd0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
